bldc_six_step_driver: RTL and testbench

Parametrised six-step (120° trapezoidal) BLDC commutation and PWM engine for the brushless motor driver boards. It takes raw hall inputs, a direction select and a duty command, and drives three high-side and three active-low low-side gate inputs. Over the current fixed-table drive it adds hall synchronisation and debounce, dead-time blanking, configurable PWM width, period and chop side, stall-triggered open-loop stepping, invalid-hall fault latching and hall-period measurement for CAN speed reporting.

---
 rtl/bldc_six_step_driver.sv | 230 +++++++++++++++++++++++
 tb/tb_bldc_six_step_driver.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bldc_six_step_driver.sv
// Six-step trapezoidal BLDC commutation: hall sync/debounce, hall-to-state map,
// PWM chopping, dead-time blanking, stall open-loop stepping, fault latch and speed capture.
module bldc_six_step_driver #(
    parameter int PWM_W       = 10,
    parameter int PWM_PERIOD  = 1000,
    parameter int PWM_SIDE    = 0,
    parameter int DEAD_CYC    = 50,
    parameter int DEB_CYC     = 16,
    parameter int STALL_CYC   = 500000,
    parameter int OL_STEP_CYC = 250000,
    parameter int SPD_W       = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             dir,
    input  logic [PWM_W-1:0] duty,
    input  logic [2:0]       hall,
    output logic [2:0]       hin,
    output logic [2:0]       lin_n,
    output logic [2:0]       step_state,
    output logic             open_loop,
    output logic             fault,
    output logic [SPD_W-1:0] hall_period,
    output logic             period_valid
);
    localparam int CNT_MAX = (STALL_CYC > OL_STEP_CYC) ? STALL_CYC : OL_STEP_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int DEB_W   = $clog2(DEB_CYC + 1);
    localparam int DEAD_W  = (DEAD_CYC > 0) ? $clog2(DEAD_CYC + 1) : 1;

    logic [2:0]       hall_s1_q, hall_s2_q;
    logic [2:0]       hall_acc_q, hall_acc_d, hall_cand_q, hall_cand_d;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic             acc_evt_q, acc_evt_d;
    logic [2:0]       state_q, state_d;
    logic             open_loop_q, open_loop_d;
    logic             fault_q, fault_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d, duty_q, duty_eff;
    logic [DEAD_W-1:0] dead_q, dead_d;
    logic [2:0]       hin_q, hin_d, lin_n_q, lin_n_d;
    logic [SPD_W-1:0] per_cnt_q, per_cnt_d, period_q, period_d;
    logic             pv_q, pv_d, armed_q, armed_d;
    logic             hall_ok, valid_evt, pwm_on, drive_ok, drive_on;
    logic [2:0]       hi_leg, lo_leg;

    function automatic logic [2:0] hall_map(input logic cw, input logic [2:0] h);
        logic [2:0] s;
        s = 3'd0;
        if (cw) begin
            case (h)
                3'd1: s = 3'd4;  3'd2: s = 3'd0;  3'd3: s = 3'd5;
                3'd4: s = 3'd2;  3'd5: s = 3'd3;  3'd6: s = 3'd1;
                default: s = 3'd0;
            endcase
        end else begin
            case (h)
                3'd1: s = 3'd1;  3'd2: s = 3'd3;  3'd3: s = 3'd2;
                3'd4: s = 3'd5;  3'd5: s = 3'd0;  3'd6: s = 3'd4;
                default: s = 3'd0;
            endcase
        end
        return s;
    endfunction

    // Debounce: count consecutive cycles the synchronised code holds a new value.
    always_comb begin
        hall_acc_d  = hall_acc_q;
        hall_cand_d = hall_cand_q;
        deb_cnt_d   = deb_cnt_q;
        acc_evt_d   = 1'b0;
        if (hall_s2_q == hall_acc_q) begin
            deb_cnt_d = '0;
        end else begin
            if (deb_cnt_q == '0 || hall_s2_q != hall_cand_q) begin
                hall_cand_d = hall_s2_q;
                deb_cnt_d   = DEB_W'(1);
            end else begin
                deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
            if (deb_cnt_d >= DEB_W'(DEB_CYC)) begin
                hall_acc_d = hall_s2_q;
                deb_cnt_d  = '0;
                acc_evt_d  = 1'b1;
            end
        end
    end

    assign hall_ok   = (hall_acc_q != 3'b000) && (hall_acc_q != 3'b111);
    assign valid_evt = acc_evt_q && hall_ok;

    // Commutation state, stall/open-loop stepping and fault latch.
    always_comb begin
        state_d     = state_q;
        open_loop_d = open_loop_q;
        stall_cnt_d = stall_cnt_q;
        fault_d     = fault_q;
        if (!enable)
            fault_d = 1'b0;
        else if (acc_evt_q && !hall_ok)
            fault_d = 1'b1;
        if (valid_evt)
            state_d = hall_map(dir, hall_acc_q);
        if (!enable || valid_evt) begin
            open_loop_d = 1'b0;
            stall_cnt_d = '0;
        end else if (!fault_q) begin
            if (!open_loop_q) begin
                if (stall_cnt_q == CNT_W'(STALL_CYC - 1)) begin
                    open_loop_d = 1'b1;
                    stall_cnt_d = '0;
                end else begin
                    stall_cnt_d = stall_cnt_q + CNT_W'(1);
                end
            end else if (stall_cnt_q == CNT_W'(OL_STEP_CYC - 1)) begin
                stall_cnt_d = '0;
                if (dir)
                    state_d = (state_q == 3'd5) ? 3'd0 : state_q + 3'd1;
                else
                    state_d = (state_q == 3'd0) ? 3'd5 : state_q - 3'd1;
            end else begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
        end
    end

    // Duty is taken straight from the input at counter 0 so the new value governs that whole period.
    assign pwm_cnt_d = (pwm_cnt_q == PWM_W'(PWM_PERIOD - 1)) ? '0 : pwm_cnt_q + PWM_W'(1);
    assign duty_eff  = (pwm_cnt_q == '0) ? duty : duty_q;
    assign pwm_on    = pwm_cnt_q < duty_eff;

    assign drive_ok = enable && !fault_q && (hall_ok || open_loop_q);
    assign drive_on = drive_ok && (dead_q == '0);

    always_comb begin
        dead_d = dead_q;
        if (!drive_ok || state_d != state_q)
            dead_d = DEAD_W'(DEAD_CYC);
        else if (dead_q != '0)
            dead_d = dead_q - DEAD_W'(1);
    end

    always_comb begin
        hi_leg = 3'b000;
        lo_leg = 3'b000;
        case (state_q)
            3'd0: begin hi_leg = 3'b001; lo_leg = 3'b010; end
            3'd1: begin hi_leg = 3'b001; lo_leg = 3'b100; end
            3'd2: begin hi_leg = 3'b010; lo_leg = 3'b100; end
            3'd3: begin hi_leg = 3'b010; lo_leg = 3'b001; end
            3'd4: begin hi_leg = 3'b100; lo_leg = 3'b001; end
            3'd5: begin hi_leg = 3'b100; lo_leg = 3'b010; end
            default: begin hi_leg = 3'b000; lo_leg = 3'b000; end
        endcase
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_leg
        assign hin_d[gi]   = drive_on & hi_leg[gi] & ((PWM_SIDE != 0) ? pwm_on : 1'b1);
        assign lin_n_d[gi] = ~(drive_on & lo_leg[gi] & ((PWM_SIDE == 0) ? pwm_on : 1'b1));
    end

    // Hall period capture; the first change after reset or enable rise only arms it.
    always_comb begin
        per_cnt_d = (&per_cnt_q) ? per_cnt_q : per_cnt_q + SPD_W'(1);
        period_d  = period_q;
        pv_d      = 1'b0;
        armed_d   = armed_q && enable;
        if (valid_evt) begin
            per_cnt_d = SPD_W'(1);
            if (enable && armed_q) begin
                period_d = per_cnt_q;
                pv_d     = 1'b1;
            end
            armed_d = enable;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hall_s1_q   <= '0;
            hall_s2_q   <= '0;
            hall_acc_q  <= '0;
            hall_cand_q <= '0;
            deb_cnt_q   <= '0;
            acc_evt_q   <= 1'b0;
            state_q     <= '0;
            open_loop_q <= 1'b0;
            fault_q     <= 1'b0;
            stall_cnt_q <= '0;
            pwm_cnt_q   <= '0;
            duty_q      <= '0;
            dead_q      <= '0;
            hin_q       <= 3'b000;
            lin_n_q     <= 3'b111;
            per_cnt_q   <= '0;
            period_q    <= '0;
            pv_q        <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            hall_s1_q   <= hall;
            hall_s2_q   <= hall_s1_q;
            hall_acc_q  <= hall_acc_d;
            hall_cand_q <= hall_cand_d;
            deb_cnt_q   <= deb_cnt_d;
            acc_evt_q   <= acc_evt_d;
            state_q     <= state_d;
            open_loop_q <= open_loop_d;
            fault_q     <= fault_d;
            stall_cnt_q <= stall_cnt_d;
            pwm_cnt_q   <= pwm_cnt_d;
            duty_q      <= duty_eff;
            dead_q      <= dead_d;
            hin_q       <= hin_d;
            lin_n_q     <= lin_n_d;
            per_cnt_q   <= per_cnt_d;
            period_q    <= period_d;
            pv_q        <= pv_d;
            armed_q     <= armed_d;
        end
    end

    assign hin          = hin_q;
    assign lin_n        = lin_n_q;
    assign step_state   = state_q;
    assign open_loop    = open_loop_q;
    assign fault        = fault_q;
    assign hall_period  = period_q;
    assign period_valid = pv_q;
endmodule

// File: tb/tb_bldc_six_step_driver.sv
// Scoreboard bench: stimulus queues expected states/periods, negedge monitors pop and compare.
module tb_bldc_six_step_driver;
    localparam int CLK_NS = 10;
    localparam int PWM_W = 10, PWM_PERIOD = 100, DEAD_CYC = 5, SPD_W = 10;
    localparam int SAT = (1 << SPD_W) - 1;

    logic             clk = 1'b0;
    logic             rst, enable, dir;
    logic [PWM_W-1:0] duty;
    logic [2:0]       hall;
    logic [2:0]       hin, lin_n, step_state;
    logic             open_loop, fault, period_valid;
    logic [SPD_W-1:0] hall_period;

    bldc_six_step_driver #(
        .PWM_W(PWM_W), .PWM_PERIOD(PWM_PERIOD), .PWM_SIDE(0), .DEAD_CYC(DEAD_CYC),
        .DEB_CYC(16), .STALL_CYC(3000), .OL_STEP_CYC(1000), .SPD_W(SPD_W)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .dir(dir), .duty(duty), .hall(hall),
        .hin(hin), .lin_n(lin_n), .step_state(step_state), .open_loop(open_loop),
        .fault(fault), .hall_period(hall_period), .period_valid(period_valid)
    );

    always #(CLK_NS / 2) clk = ~clk;

    int n_vec = 0, n_miss = 0, cyc = 0;
    int exp_state_q[$];
    int exp_period_q[$];
    bit mon_en = 0;
    int cur_state = 0, last_acc_cyc = 0;
    bit armed = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int pat_hin(input int s);
        case (s)
            0, 1: return 1; 2, 3: return 2; default: return 4;
        endcase
    endfunction

    function automatic int pat_lin_n(input int s);
        case (s)
            0, 5: return 5; 1, 2: return 3; default: return 6;
        endcase
    endfunction

    // State-change monitor: sequence, blanking length and post-blank pattern (full duty assumed).
    int  prev_state = 0, blank_cnt = 0;
    bit  in_blank = 0;
    always @(negedge clk) begin
        if (rst || !mon_en) begin
            in_blank = 0;
        end else if (step_state != prev_state) begin
            if (exp_state_q.size() == 0) begin
                n_vec++; n_miss++;
                $display("FAIL state_unexpected: got %0d expected none", step_state);
            end else begin
                check("state_seq", int'(step_state), exp_state_q.pop_front());
            end
            in_blank = 1;
            blank_cnt = 0;
        end else if (in_blank) begin
            if (hin == 3'b000 && lin_n == 3'b111) begin
                blank_cnt++;
                if (blank_cnt > DEAD_CYC + 20) begin
                    check("dead_timeout", blank_cnt, DEAD_CYC);
                    in_blank = 0;
                end
            end else begin
                check("dead_cycles", blank_cnt, DEAD_CYC);
                check("pattern_hin", int'(hin), pat_hin(int'(step_state)));
                check("pattern_lin_n", int'(lin_n), pat_lin_n(int'(step_state)));
                in_blank = 0;
            end
        end
        prev_state = int'(step_state);
    end

    always @(negedge clk) begin
        if (!rst && period_valid) begin
            if (exp_period_q.size() == 0) begin
                n_vec++; n_miss++;
                $display("FAIL period_unexpected: got %0d expected none", hall_period);
            end else begin
                check("hall_period", int'(hall_period), exp_period_q.pop_front());
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic hall_step(input logic [2:0] code, input int exp_state);
        int d;
        hall = code;
        d = cyc - last_acc_cyc;
        if (d > SAT) d = SAT;
        if (armed && enable) exp_period_q.push_back(d);
        if (exp_state != cur_state) exp_state_q.push_back(exp_state);
        $display("hall %0d -> expect state %0d", code, exp_state);
        cur_state = exp_state;
        last_acc_cyc = cyc;
        armed = enable;
    endtask

    task automatic count_on(output int lo_on, output int hi_on);
        lo_on = 0; hi_on = 0;
        for (int k = 0; k < PWM_PERIOD; k++) begin
            wait_cyc(1);
            if (lin_n[1] == 1'b0) lo_on++;
            if (hin[0]) hi_on++;
        end
    endtask

    task automatic wait_fall(output bit ok);
        logic p;
        ok = 0;
        p = lin_n[1];
        for (int k = 0; k < 300; k++) begin
            wait_cyc(1);
            if (p == 1'b1 && lin_n[1] == 1'b0) begin ok = 1; break; end
            p = lin_n[1];
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_hin"}, int'(hin), 0);
        check({tag, "_lin_n"}, int'(lin_n), 7);
        check({tag, "_state"}, int'(step_state), 0);
        check({tag, "_open_loop"}, int'(open_loop), 0);
        check({tag, "_fault"}, int'(fault), 0);
        check({tag, "_period"}, int'(hall_period), 0);
        check({tag, "_pvalid"}, int'(period_valid), 0);
    endtask

    initial begin
        #(CLK_NS * 100000);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int lo, hi, run;
        bit ok;
        rst = 1; enable = 0; dir = 1; duty = '0; hall = 3'd0;
        wait_cyc(3);
        check_reset_vals("reset");
        rst = 0;
        enable = 1; duty = 10'(PWM_PERIOD);
        mon_en = 1;
        // Initial sync to hall 2 (state 0), then one CW revolution.
        hall_step(3'd2, 0);
        wait_cyc(60);
        check("init_state", int'(step_state), 0);
        check("init_hin", int'(hin), 1);
        check("init_lin_n", int'(lin_n), 5);
        wait_cyc(940);
        hall_step(3'd6, 1); wait_cyc(1000);
        hall_step(3'd4, 2); wait_cyc(1000);
        hall_step(3'd5, 3); wait_cyc(1000);
        hall_step(3'd1, 4); wait_cyc(1000);
        hall_step(3'd3, 5); wait_cyc(1000);
        check("cw_period", int'(hall_period), 1000);
        hall_step(3'd2, 0); wait_cyc(100);

        // PWM on low S in state 0.
        duty = 10'd0; wait_cyc(200);
        count_on(lo, hi);
        check("pwm0_lo", lo, 0);
        check("pwm0_hi", hi, PWM_PERIOD);
        duty = 10'd50; wait_cyc(200);
        count_on(lo, hi);
        check("pwm50_lo", lo, 50);
        check("pwm50_hi", hi, PWM_PERIOD);
        wait_fall(ok);
        check("pwm_fall_a", int'(ok), 1);
        run = 1;
        for (int k = 0; k < 300; k++) begin
            wait_cyc(1);
            if (k == 9) duty = 10'd80;
            if (lin_n[1] != 1'b0) break;
            run++;
        end
        check("pwm_midchange_old", run, 50);
        wait_fall(ok);
        check("pwm_fall_b", int'(ok), 1);
        run = 1;
        for (int k = 0; k < 300; k++) begin
            wait_cyc(1);
            if (lin_n[1] != 1'b0) break;
            run++;
        end
        check("pwm_midchange_new", run, 80);
        duty = 10'd1023; wait_cyc(200);
        count_on(lo, hi);
        check("pwm_over_lo", lo, PWM_PERIOD);
        duty = 10'(PWM_PERIOD);

        // Debounce boundary: 10 and 15 cycle glitches rejected, 16 accepted.
        hall = 3'd6; wait_cyc(10); hall = 3'd2; wait_cyc(40);
        check("glitch10_state", int'(step_state), 0);
        hall = 3'd6; wait_cyc(15); hall = 3'd2; wait_cyc(40);
        check("glitch15_state", int'(step_state), 0);
        hall_step(3'd6, 1); wait_cyc(16);
        hall_step(3'd2, 0);

        // Stall: open loop after 3000 cycles, CCW steps every 1000.
        wait_cyc(2990);
        check("stall_pre_ol", int'(open_loop), 0);
        dir = 0;
        exp_state_q.push_back(5);
        exp_state_q.push_back(4);
        cur_state = 4;
        wait_cyc(110);
        check("stall_ol", int'(open_loop), 1);
        wait_cyc(2400);
        check("ol_state", int'(step_state), 4);
        check("ol_still", int'(open_loop), 1);
        hall_step(3'd1, 1); wait_cyc(100);
        check("ol_exit", int'(open_loop), 0);
        check("ol_exit_state", int'(step_state), 1);
        check("period_sat", int'(hall_period), SAT);

        // Invalid hall fault.
        hall = 3'd7; wait_cyc(100);
        check("fault_set", int'(fault), 1);
        check("fault_hin", int'(hin), 0);
        check("fault_lin_n", int'(lin_n), 7);
        hall_step(3'd1, 1); wait_cyc(100);
        check("fault_sticky", int'(fault), 1);
        check("fault_sticky_hin", int'(hin), 0);
        check("fault_sticky_lin_n", int'(lin_n), 7);
        enable = 0; armed = 0; wait_cyc(5);
        check("fault_clr", int'(fault), 0);
        hall = 3'd7; wait_cyc(50);
        check("fault_dis_invalid", int'(fault), 0);
        hall_step(3'd1, 1); wait_cyc(50);
        enable = 1; wait_cyc(30);
        check("reen_fault", int'(fault), 0);
        check("reen_hin", int'(hin), 1);
        check("reen_lin_n", int'(lin_n), 3);

        // Reset mid-PWM.
        check("sb_state_left", exp_state_q.size(), 0);
        check("sb_period_left", exp_period_q.size(), 0);
        mon_en = 0;
        duty = 10'd50; wait_cyc(37);
        rst = 1; wait_cyc(1);
        check_reset_vals("midrst");
        rst = 0; wait_cyc(10);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
